cs_seq: RTL and testbench

Parametrised control-section flag sequencer. Drives up to NSTAGE downstream engines (UDP, FIFO, MAC, ADC check/conf/read/fifo, ...) through an fs/fd four-phase handshake in a masked order, with single-pass and continuous-loop modes. Adds a per-stage timeout with error reporting, a hold gate for FIFO back-pressure, and abort. Sits inside the cs top beside the command decoder, which supplies the mask and mode and starts the run.

---
 rtl/cs_seq_pkg.sv | 17 +
 rtl/cs_seq_pick.sv | 46 ++++
 rtl/cs_seq.sv | 195 +++++++++++++++++++
 tb/tb_cs_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_seq_pkg.sv
// cs_seq_pkg: shared types and helpers for the control-section flag sequencer.
//   state_t : sequencer FSM states
//   idx_w   : index width for a stage count ($clog2 with a floor of 1)
package cs_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_REQ  = 2'd2,
      S_REL  = 2'd3
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cs_seq_pick.sv
// cs_seq_pick: combinational stage selector for cs_seq.
//   mask  : enabled stages
//   cur   : currently active stage
//   mode  : wrap allowed (continuous run with no stop pending)
//   first : lowest enabled index (0 when mask is empty)
//   nxt   : next enabled index above cur; when none exists, first if mode
//           is set, otherwise cur
//   found : an enabled index above cur exists
module cs_seq_pick
   import cs_seq_pkg::*;
#(
   parameter int NSTAGE = 8
) (
   input  logic [NSTAGE-1:0]            mask,
   input  logic [idx_w(NSTAGE)-1:0]     cur,
   input  logic                         mode,
   output logic [idx_w(NSTAGE)-1:0]     first,
   output logic [idx_w(NSTAGE)-1:0]     nxt,
   output logic                         found
);

   localparam int IW = idx_w(NSTAGE);

   logic [IW-1:0] hi_idx;
   logic          hi_ok;

   // Scan downwards so the lowest matching index is the last one written.
   always_comb begin
      first  = '0;
      hi_idx = '0;
      hi_ok  = 1'b0;
      for (int i = NSTAGE - 1; i >= 0; i--) begin
         if (mask[i]) begin
            first = IW'(i);
            if (i > int'(cur)) begin
               hi_idx = IW'(i);
               hi_ok  = 1'b1;
            end
         end
      end
   end

   assign found = hi_ok;
   assign nxt   = hi_ok ? hi_idx : (mode ? first : cur);

endmodule

// File: rtl/cs_seq.sv
// cs_seq: control-section flag sequencer. Walks the enabled stages in
// ascending order through an fs/fd four-phase handshake, once or in a loop.
//   clk, rst      : clock, synchronous active-high reset
//   start         : run request (IDLE only); mode/stage_en/tmo_limit latched
//   hold          : blocks raising a new fs
//   stop          : continuous mode ends after the current pass
//   abort         : immediate return to IDLE, no done/err
//   fs / fd       : per-stage start / done flags
//   busy, done    : run in progress, completion pulse
//   err, err_stage: timeout pulse and the stage that timed out
//   cur_stage     : active stage, loop_cnt: completed passes this run
//
// state | meaning
// IDLE  | waiting for start
// ARM   | fs low, waiting for hold to clear before raising fs[cur_stage]
// REQ   | fs[cur_stage] high, waiting for fd[cur_stage] high
// REL   | fs low, waiting for fd[cur_stage] low, then pick the next stage
module cs_seq
   import cs_seq_pkg::*;
#(
   parameter int NSTAGE = 8,
   parameter int TMO_W  = 16,
   parameter int LCNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         mode,
   input  logic [NSTAGE-1:0]            stage_en,
   input  logic [TMO_W-1:0]             tmo_limit,
   input  logic                         hold,
   input  logic                         stop,
   input  logic                         abort,
   output logic [NSTAGE-1:0]            fs,
   input  logic [NSTAGE-1:0]            fd,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [idx_w(NSTAGE)-1:0]     err_stage,
   output logic [idx_w(NSTAGE)-1:0]     cur_stage,
   output logic [LCNT_W-1:0]            loop_cnt
);

   localparam int IW = idx_w(NSTAGE);
   localparam logic [NSTAGE-1:0] ONE = NSTAGE'(1);

   state_t              state_q, state_n;
   logic                mode_q, mode_n;
   logic [NSTAGE-1:0]   mask_q, mask_n;
   logic [TMO_W-1:0]    lim_q, lim_n;
   logic [TMO_W-1:0]    tmo_q, tmo_n;
   logic                stop_pend_q, stop_pend_n;
   logic [NSTAGE-1:0]   fs_n;
   logic                busy_n, done_n, err_n;
   logic [IW-1:0]       err_stage_n, cur_n;
   logic [LCNT_W-1:0]   loop_n;

   logic [NSTAGE-1:0]   pick_mask;
   logic [IW-1:0]       pick_first, pick_nxt;
   logic                pick_found;
   logic                fd_cur, tmo_hit;

   // In IDLE the live mask is needed to find the first stage at start.
   assign pick_mask = (state_q == S_IDLE) ? stage_en : mask_q;
   assign fd_cur    = fd[cur_stage];
   assign tmo_hit   = (lim_q != '0) && (tmo_q == lim_q);

   cs_seq_pick #(.NSTAGE(NSTAGE)) u_pick (
      .mask  (pick_mask),
      .cur   (cur_stage),
      .mode  (mode_q & ~stop_pend_q),
      .first (pick_first),
      .nxt   (pick_nxt),
      .found (pick_found)
   );

   always_comb begin
      state_n     = state_q;
      mode_n      = mode_q;
      mask_n      = mask_q;
      lim_n       = lim_q;
      tmo_n       = tmo_q;
      stop_pend_n = stop_pend_q;
      fs_n        = '0;
      busy_n      = busy;
      done_n      = 1'b0;
      err_n       = 1'b0;
      err_stage_n = err_stage;
      cur_n       = cur_stage;
      loop_n      = loop_cnt;

      if (state_q != S_IDLE && stop) stop_pend_n = 1'b1;
      if (state_q == S_REQ || state_q == S_REL) tmo_n = tmo_q + 1'b1;

      if (abort) begin
         state_n = S_IDLE;
         busy_n  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               busy_n = 1'b0;
               if (start) begin
                  mode_n      = mode;
                  mask_n      = stage_en;
                  lim_n       = tmo_limit;
                  loop_n      = '0;
                  stop_pend_n = 1'b0;
                  if (stage_en == '0) begin
                     done_n = 1'b1;
                  end else begin
                     cur_n   = pick_first;
                     state_n = S_ARM;
                     busy_n  = 1'b1;
                  end
               end
            end
            S_ARM: begin
               if (!hold) begin
                  fs_n    = ONE << cur_stage;
                  tmo_n   = '0;
                  state_n = S_REQ;
               end
            end
            S_REQ: begin
               if (fd_cur) begin
                  state_n = S_REL;
               end else if (tmo_hit) begin
                  err_n       = 1'b1;
                  err_stage_n = cur_stage;
                  busy_n      = 1'b0;
                  state_n     = S_IDLE;
               end else begin
                  fs_n = ONE << cur_stage;
               end
            end
            S_REL: begin
               if (!fd_cur) begin
                  if (pick_found) begin
                     cur_n   = pick_nxt;
                     state_n = S_ARM;
                  end else if (mode_q && !stop_pend_q) begin
                     loop_n  = loop_cnt + 1'b1;
                     cur_n   = pick_nxt;
                     state_n = S_ARM;
                  end else begin
                     loop_n  = loop_cnt + 1'b1;
                     done_n  = 1'b1;
                     busy_n  = 1'b0;
                     state_n = S_IDLE;
                  end
               end else if (tmo_hit) begin
                  err_n       = 1'b1;
                  err_stage_n = cur_stage;
                  busy_n      = 1'b0;
                  state_n     = S_IDLE;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         mask_q      <= '0;
         lim_q       <= '0;
         tmo_q       <= '0;
         stop_pend_q <= 1'b0;
         fs          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_stage   <= '0;
         cur_stage   <= '0;
         loop_cnt    <= '0;
      end else begin
         state_q     <= state_n;
         mode_q      <= mode_n;
         mask_q      <= mask_n;
         lim_q       <= lim_n;
         tmo_q       <= tmo_n;
         stop_pend_q <= stop_pend_n;
         fs          <= fs_n;
         busy        <= busy_n;
         done        <= done_n;
         err         <= err_n;
         err_stage   <= err_stage_n;
         cur_stage   <= cur_n;
         loop_cnt    <= loop_n;
      end
   end

endmodule

// File: tb/tb_cs_seq.sv
// tb_cs_seq: self-checking bench for cs_seq. A cycle-stepped responder
// answers fs with fd; the order of fs rises is compared against a list of
// expected stages built from the mask and number of passes.
module tb_cs_seq;

   localparam int NS = 8;
   localparam int TW = 16;
   localparam int LW = 16;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst, start, mode, hold, stop, abort;
   logic [NS-1:0] stage_en, fd, fs;
   logic [TW-1:0] tmo_limit;
   logic          busy, done, err;
   logic [IW-1:0] err_stage, cur_stage;
   logic [LW-1:0] loop_cnt;

   always #5 clk = ~clk;

   cs_seq #(.NSTAGE(NS), .TMO_W(TW), .LCNT_W(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .stage_en(stage_en),
      .tmo_limit(tmo_limit), .hold(hold), .stop(stop), .abort(abort),
      .fs(fs), .fd(fd), .busy(busy), .done(done), .err(err),
      .err_stage(err_stage), .cur_stage(cur_stage), .loop_cnt(loop_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_done, n_err, bad_oh;
   int order[$];
   int exp_q[$];
   logic [NS-1:0] prev_fs = '0;
   bit resp_en = 1'b0;
   bit rnd_hold = 1'b0;
   int fix_dly = 0;
   int wait_cnt = 0;
   int rel_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pick_dly();
      return (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 5));
   endfunction

   // One clock: sample 1 ns after the edge, observe, then drive the responder.
   task automatic step();
      @(posedge clk);
      #1;
      if ($countones(fs) > 1) bad_oh++;
      if (fs != '0 && prev_fs == '0) begin
         for (int i = 0; i < NS; i++) if (fs[i]) order.push_back(i);
         wait_cnt = pick_dly();
      end
      n_done += int'(done);
      n_err  += int'(err);
      if (resp_en) begin
         if (fs != '0 && fd == '0) begin
            if (wait_cnt == 0) begin
               fd = fs;
               rel_cnt = (fix_dly >= 0) ? 0 : int'($urandom_range(0, 3));
            end else begin
               wait_cnt--;
            end
         end else if (fs == '0 && fd != '0) begin
            if (rel_cnt == 0) fd = '0;
            else rel_cnt--;
         end
      end
      if (rnd_hold) hold = ($urandom_range(0, 3) == 0);
      prev_fs = fs;
   endtask

   task automatic clear_obs();
      n_done = 0;
      n_err  = 0;
      bad_oh = 0;
      order.delete();
   endtask

   // Reference: each pass visits the enabled stages in ascending order.
   task automatic build_exp(input logic [NS-1:0] m, input int passes);
      exp_q.delete();
      for (int p = 0; p < passes; p++)
         for (int i = 0; i < NS; i++)
            if (m[i]) exp_q.push_back(i);
   endtask

   task automatic cmp_order(input string tag);
      chk({tag, "_len"}, 32'(order.size()), 32'(exp_q.size()));
      for (int i = 0; i < order.size() && i < exp_q.size(); i++)
         chk({tag, "_stage"}, 32'(order[i]), 32'(exp_q[i]));
   endtask

   task automatic do_start(input logic [NS-1:0] m, input logic md, input logic [TW-1:0] lim);
      stage_en  = m;
      mode      = md;
      tmo_limit = lim;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      bit got;
      got = done || err;
      for (int k = 0; k < 3000 && !got; k++) begin
         step();
         got = done || err;
      end
      chk({tag, "_end"}, 32'(got), 1);
   endtask

   task automatic wait_fs(input string tag, input logic [NS-1:0] pat);
      bit got;
      got = (fs == pat);
      for (int k = 0; k < 200 && !got; k++) begin
         step();
         got = (fs == pat);
      end
      chk({tag, "_fs_seen"}, 32'(got), 1);
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_fs"}, 32'(fs), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; hold = 1'b0; stop = 1'b0;
      abort = 1'b0; stage_en = '0; tmo_limit = '0; fd = '0;
      repeat (3) step();
      rst = 1'b0;
      check_idle_zero("reset");
      chk("reset_err_stage", 32'(err_stage), 0);
      chk("reset_cur_stage", 32'(cur_stage), 0);
      chk("reset_loop_cnt", 32'(loop_cnt), 0);

      // single pass, stages 0 and 2, fixed responder delay
      clear_obs(); resp_en = 1'b1; fix_dly = 3;
      do_start(8'h05, 1'b0, '0);
      chk("sp_busy_t1", 32'(busy), 1);
      chk("sp_fs_t1", 32'(fs), 0);
      step();
      chk("sp_fs_t2", 32'(fs), 1);
      wait_end("sp");
      chk("sp_busy_at_done", 32'(busy), 0);
      chk("sp_loop_cnt", 32'(loop_cnt), 1);
      step();
      chk("sp_done_width", 32'(done), 0);
      chk("sp_n_done", 32'(n_done), 1);
      chk("sp_n_err", 32'(n_err), 0);
      chk("sp_onehot", 32'(bad_oh), 0);
      build_exp(8'h05, 1); cmp_order("sp");

      // empty mask
      clear_obs();
      do_start(8'h00, 1'b0, '0);
      chk("empty_done_t1", 32'(done), 1);
      chk("empty_fs", 32'(fs), 0);
      chk("empty_busy", 32'(busy), 0);
      step();
      chk("empty_done_width", 32'(done), 0);
      chk("empty_n_err", 32'(n_err), 0);
      chk("empty_order", 32'(order.size()), 0);

      // timeout on stage 1, limit 10: err 11 cycles after fs rises
      clear_obs(); resp_en = 1'b0; fd = '0;
      do_start(8'h02, 1'b0, 16'd10);
      wait_fs("tmo", 8'h02);
      begin
         int k;
         k = 0;
         while (!err && k < 100) begin
            step();
            k++;
         end
         chk("tmo_err_delay", 32'(k), 11);
      end
      chk("tmo_err_stage", 32'(err_stage), 1);
      chk("tmo_fs_at_err", 32'(fs), 0);
      chk("tmo_busy_at_err", 32'(busy), 0);
      step();
      chk("tmo_err_width", 32'(err), 0);
      chk("tmo_err_stage_hold", 32'(err_stage), 1);
      chk("tmo_n_done", 32'(n_done), 0);

      // continuous, stop during pass 2
      clear_obs(); resp_en = 1'b1; fix_dly = -1;
      do_start(8'h03, 1'b1, '0);
      for (int k = 0; k < 500 && loop_cnt != 1 && !done; k++) step();
      stop = 1'b1; step(); stop = 1'b0;
      wait_end("cont");
      chk("cont_loop_cnt", 32'(loop_cnt), 2);
      step();
      chk("cont_n_done", 32'(n_done), 1);
      chk("cont_n_err", 32'(n_err), 0);
      build_exp(8'h03, 2); cmp_order("cont");

      // hold across the stage 0 -> 1 transition
      clear_obs(); fix_dly = 2;
      do_start(8'h03, 1'b0, '0);
      wait_fs("hold", 8'h01);
      hold = 1'b1;
      begin
         int viol;
         viol = 0;
         repeat (12) begin
            step();
            if (fs[1]) viol++;
         end
         chk("hold_fs1_blocked", 32'(viol), 0);
      end
      chk("hold_fs_low", 32'(fs), 0);
      chk("hold_cur_stage", 32'(cur_stage), 1);
      hold = 1'b0;
      step();
      chk("hold_release_fs", 32'(fs), 2);
      wait_end("hold");
      chk("hold_loop_cnt", 32'(loop_cnt), 1);

      // abort and start together in IDLE: start ignored
      clear_obs();
      abort = 1'b1; stage_en = 8'h01; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      chk("abst_busy", 32'(busy), 0);
      chk("abst_done", 32'(done), 0);

      // abort while in REQ on stage 3, then a clean run
      clear_obs(); fix_dly = 3;
      do_start(8'h2A, 1'b0, '0);
      wait_fs("abort", 8'h08);
      abort = 1'b1; step(); abort = 1'b0;
      check_idle_zero("abort");
      repeat (5) step();
      chk("abort_n_done", 32'(n_done), 0);
      chk("abort_n_err", 32'(n_err), 0);
      clear_obs(); fix_dly = -1;
      do_start(8'h2A, 1'b0, '0);
      wait_end("abort_rerun");
      build_exp(8'h2A, 1); cmp_order("abort_rerun");

      // synchronous reset while in REQ on stage 3, then a clean run
      clear_obs(); fix_dly = 3;
      do_start(8'h2A, 1'b1, 16'd200);
      wait_fs("rst", 8'h08);
      rst = 1'b1; step(); rst = 1'b0;
      check_idle_zero("rst");
      chk("rst_err_stage", 32'(err_stage), 0);
      chk("rst_cur_stage", 32'(cur_stage), 0);
      repeat (5) step();
      chk("rst_n_done", 32'(n_done), 0);
      clear_obs(); fix_dly = -1;
      do_start(8'h2A, 1'b0, '0);
      wait_end("rst_rerun");
      build_exp(8'h2A, 1); cmp_order("rst_rerun");

      // randomized runs with random hold, late input changes ignored
      for (int it = 0; it < 25; it++) begin
         logic [NS-1:0] m;
         logic          md;
         int            tgt, passes;
         m   = NS'($urandom_range(0, 255));
         if (it % 8 == 0) m = '0;
         md  = 1'($urandom_range(0, 1));
         tgt = int'($urandom_range(1, 3));
         clear_obs(); rnd_hold = 1'b1;
         do_start(m, md, ($urandom_range(0, 1) == 1) ? 16'd60 : 16'd0);
         stage_en = NS'($urandom);
         mode = ~md;
         if (md && m != '0) begin
            for (int k = 0; k < 2000 && int'(loop_cnt) != tgt - 1 && !done; k++) step();
            stop = 1'b1; step(); stop = 1'b0;
         end
         wait_end("rnd");
         passes = (m == '0) ? 0 : (md ? tgt : 1);
         chk("rnd_loop_cnt", 32'(loop_cnt), 32'(passes));
         rnd_hold = 1'b0; hold = 1'b0;
         step();
         chk("rnd_n_done", 32'(n_done), 1);
         chk("rnd_n_err", 32'(n_err), 0);
         chk("rnd_onehot", 32'(bad_oh), 0);
         build_exp(m, passes); cmp_order("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
